// File: rtl/lsu_mem_stage.sv
// Load/store stage: one data-memory transaction per request over a req/ack bus,
// with lane steering, strobes, load extension, alignment check and bus timeout.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        lsu_start,
    input  logic [2:0]  lsu_op,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_ale,
    output logic        lsu_berr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 32'd1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_cnt;
    logic        w_accept;
    logic        w_misal;
    logic        w_timeout;

    function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        case (op)
            3'b001, 3'b100, 3'b110: bad = lane[0];
            3'b010, 3'b111:         bad = |lane;
            default:                bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_strb(input logic [2:0] op, input logic [1:0] lane);
        logic [3:0] s;
        case (op)
            3'b101:  s = 4'b0001 << lane;
            3'b110:  s = 4'b0011 << {lane[1], 1'b0};
            3'b111:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] d;
        case (op)
            3'b101:  d = {4{wd[7:0]}};
            3'b110:  d = {2{wd[15:0]}};
            3'b111:  d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] lane,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'b000:  v = {{24{b[7]}}, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b010:  v = rd;
            3'b011:  v = {24'h00_0000, b};
            3'b100:  v = {16'h0000, h};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    // Request acceptance, alignment and timeout decode.
    always_comb begin
        w_accept  = lsu_start && (r_state != S_REQ);
        w_misal   = f_misaligned(lsu_op, lsu_addr[1:0]);
        w_timeout = (TIMEOUT != 32'd0) && !dm_ack && (r_cnt == TMO_LAST);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = w_misal ? S_DONE : S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (dm_ack || w_timeout) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs and request context; dm_* only change on an accepted aligned start.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_op      <= 3'b000;
            r_lane    <= 2'b00;
            r_cnt     <= 32'd0;
            lsu_busy  <= 1'b0;
            lsu_done  <= 1'b0;
            lsu_rdata <= 32'h0000_0000;
            lsu_ale   <= 1'b0;
            lsu_berr  <= 1'b0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'h0000_0000;
            dm_wstrb  <= 4'b0000;
            dm_wdata  <= 32'h0000_0000;
        end else begin
            lsu_done <= (w_next == S_DONE);
            lsu_busy <= (w_next == S_REQ);
            dm_req   <= (w_next == S_REQ);
            if (w_accept) begin
                r_op      <= lsu_op;
                r_lane    <= lsu_addr[1:0];
                r_cnt     <= 32'd0;
                lsu_rdata <= 32'h0000_0000;
                lsu_berr  <= 1'b0;
                lsu_ale   <= w_misal;
                if (!w_misal) begin
                    dm_addr  <= {lsu_addr[31:2], 2'b00};
                    dm_we    <= (lsu_op >= 3'b101);
                    dm_wstrb <= f_strb(lsu_op, lsu_addr[1:0]);
                    dm_wdata <= f_wdata(lsu_op, lsu_wdata);
                end
            end else if (r_state == S_REQ) begin
                if (dm_ack) begin
                    if (!dm_we) begin
                        lsu_rdata <= f_load(r_op, r_lane, dm_rdata);
                    end
                end else if (w_timeout) begin
                    lsu_berr <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit directly downstream of the ALU in the miniLA CPU. It takes the ALU result (`alu_c`) as the effective address and `rf_rD2` as the store data, then runs one data-memory transaction per request over a req/ack bus. It performs byte-lane steering, write-strobe generation, load extraction with sign or zero extension, alignment checking and bus timeout. It stalls the core through `lsu_busy` until the access completes.

## Interface
- `TIMEOUT`, default 16: number of `REQ` cycles without ack before the access aborts; 0 disables the timeout.
- `cpu_clk` input 1: clock; everything updates on the rising edge.
- `cpu_rst` input 1: synchronous, active-high reset.
- `lsu_start` input 1: single-cycle request; accepted only when `lsu_busy`=0.
- `lsu_op` input 3: operation code.
  - 000 LD_B, 001 LD_H, 010 LD_W, 011 LD_BU, 100 LD_HU.
  - 101 ST_B, 110 ST_H, 111 ST_W.
- `lsu_addr` input 32: effective address (the ALU's `alu_c`).
- `lsu_wdata` input 32: store source (`rf_rD2`).
- `lsu_busy` output 1: high while in `REQ`.
- `lsu_done` output 1: one-cycle completion pulse.
- `lsu_rdata` output 32: extended load result; held until the next accepted start.
- `lsu_ale` output 1: alignment error, valid with `lsu_done`.
- `lsu_berr` output 1: bus timeout error, valid with `lsu_done`.
- `dm_req` output 1: bus request.
- `dm_we` output 1: 1 = write.
- `dm_addr` output 32: word-aligned address `{addr[31:2],2'b00}`.
- `dm_wstrb` output 4: byte-lane write enables; 0000 for loads.
- `dm_wdata` output 32: lane-replicated store data.
- `dm_ack` input 1: bus accepts/completes the access in this cycle.
- `dm_rdata` input 32: read word, valid in the ack cycle.

## Operation
- FSM states: `IDLE`, `REQ`, `DONE`.
- Accepting a start (`IDLE` or `DONE`, with `lsu_start`=1):
  - Latch op, address and data.
  - Clear `lsu_ale`, `lsu_berr` and `lsu_rdata`.
- Alignment check on start:
  - Halfword ops require addr[0]=0.
  - Word ops require addr[1:0]=00.
  - Byte ops are never misaligned.
  - A misaligned access goes to `DONE` with `lsu_ale`=1 and never asserts `dm_req`.
- `REQ` state:
  - `dm_req`=1; all `dm_*` outputs stay stable until ack.
  - On `dm_ack`=1 the FSM goes to `DONE`; a load captures `dm_rdata` in the same cycle.
- Timeout: a counter increments each `REQ` cycle without ack. Reaching `TIMEOUT` moves the FSM to `DONE` with `lsu_berr`=1 and `lsu_rdata` unchanged (0).
- `DONE` state:
  - `lsu_done`=1 for exactly one cycle.
  - Returns to `IDLE`, or accepts a new start in that same cycle (back-to-back).
- Store strobes:
  - ST_B: `4'b0001 << addr[1:0]`.
  - ST_H: `4'b0011 << {addr[1],1'b0}`.
  - ST_W: `4'b1111`.
- Store data:
  - ST_B: `{4{wdata[7:0]}}`.
  - ST_H: `{2{wdata[15:0]}}`.
  - ST_W: `wdata`.
- Load extraction:
  - Byte: byte `addr[1:0]` of `dm_rdata`.
  - Halfword: half `addr[1]`.
  - LD_B and LD_H sign-extend; LD_BU and LD_HU zero-extend; LD_W passes the word unchanged.
- `lsu_start` while `lsu_busy`=1 is ignored, with no side effects.
- Reset mid-transaction: next edge goes to `IDLE`, `dm_req`=0, no `lsu_done` issued, and the timeout counter clears.

## Timing
- Reset values: every output is 0, including `lsu_rdata`, `dm_addr`, `dm_wstrb` and `dm_wdata`; state is `IDLE`.
- All outputs are registered; no input-to-output combinational path.
- Aligned access with start at cycle N:
  - `dm_req` rises at N+1.
  - Fastest completion: ack at N+1 gives `lsu_done` at N+2.
  - Ack at cycle N+k gives `lsu_done` at N+k+1.
- Misaligned access with start at N: `lsu_done` and `lsu_ale` at N+1; `dm_req` stays 0.
- Timeout with start at N, no ack: `dm_req` is high from N+1 to N+TIMEOUT; `lsu_done` and `lsu_berr` at N+TIMEOUT+1.
- Back-to-back: a start in the `DONE` cycle makes `dm_req` rise on the next cycle.
- Ack sampled outside `REQ` is ignored.

## Test plan
- LD_B at 0x0000_1003, `dm_rdata`=0x80FF_1234, ack on the first req cycle:
  - `dm_addr`=0x0000_1000, `dm_wstrb`=0000.
  - Two cycles after start: `lsu_done`=1, `lsu_rdata`=0xFFFF_FF80.
  - Repeat as LD_BU: `lsu_rdata`=0x0000_0080.
- ST_H at 0x0000_2002, wdata 0xABCD_1234, ack after 3 wait cycles:
  - `dm_we`=1, `dm_wstrb`=1100, `dm_wdata`=0x1234_1234, all held stable through the wait.
  - `lsu_done` the cycle after ack.
- LD_W at 0x0000_1001:
  - `lsu_done`=1 and `lsu_ale`=1 one cycle after start.
  - `dm_req` never asserts; `lsu_rdata`=0.
- LD_HU at 0x0000_3000, no ack, `TIMEOUT`=16:
  - `dm_req` high for 16 cycles.
  - Then `lsu_done` with `lsu_berr`=1.
- Back-to-back ST_W 0x10 then LD_W 0x10 with the second start in the `DONE` cycle:
  - Second `dm_req` the next cycle.
  - The load returns the ack data.
  - A `lsu_start` pulsed while busy is ignored.
- Reset asserted during `REQ`: on the next edge `dm_req`=0, all outputs 0, and no `lsu_done` ever pulses for the aborted access.
